// File: rtl/ch_serializer_pkg.sv
// Shared defaults and FSM encoding for the channel serializer.
package ch_pkg;

   localparam int NCH_DEF = 8;
   localparam int W_DEF   = 16;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

endpackage

// File: rtl/ch_serializer_if.sv
// Frame-in / sample-out bus of the channel serializer.
interface ch_serializer_if
   import ch_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int W   = W_DEF
);
   localparam int CW = $clog2(NCH);

   logic [CW:0]      numch;
   logic             in_strobe;
   logic [NCH*W-1:0] d_in;
   logic             out_ready;
   logic             out_valid;
   logic [W-1:0]     d_out;
   logic [CW-1:0]    ch_idx;
   logic [NCH-1:0]   ch_onehot;
   logic             sof;
   logic             eof;

   modport master (
      output numch, in_strobe, d_in, out_ready,
      input  out_valid, d_out, ch_idx, ch_onehot, sof, eof
   );

   modport slave (
      input  numch, in_strobe, d_in, out_ready,
      output out_valid, d_out, ch_idx, ch_onehot, sof, eof
   );

endinterface

// File: rtl/ch_serializer.sv
// Captures a multi-channel frame on in_strobe and emits it one channel per transfer.
// Latency 1 from strobe to first sample; out_ready stalls in place; a strobe mid-frame is dropped and flagged.
module ch_serializer
   import ch_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int W   = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   ch_serializer_if.slave bus,
   input  logic           clr_overrun,
   output logic           busy,
   output logic           overrun
);
   localparam int              CW    = $clog2(NCH);
   localparam logic [CW:0]     NCH_V = (CW+1)'(NCH);
   localparam logic [NCH-1:0]  ONE   = NCH'(1);

   logic [0:0]       state;
   logic [CW-1:0]    sel;
   logic [CW-1:0]    n_last;
   logic [NCH*W-1:0] frame;
   logic [CW:0]      n_eff;
   logic [CW-1:0]    n_last_nxt;
   logic             valid;
   logic             last;
   logic             xfer;
   logic             take;
   logic             drop;

   always_comb begin
      n_eff      = (bus.numch > NCH_V) ? NCH_V : bus.numch;
      n_last_nxt = CW'(n_eff - (CW+1)'(1));
   end

   assign valid = (state == SEND);
   assign last  = (sel == n_last);
   assign xfer  = valid & bus.out_ready;

   // A strobe landing on the final transfer chains straight into the next frame.
   assign take = bus.in_strobe & (bus.numch != '0) & (~valid | (xfer & last));
   assign drop = bus.in_strobe & valid & ~(xfer & last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         n_last  <= '0;
         overrun <= 1'b0;
      end else begin
         if (take) begin
            state  <= SEND;
            sel    <= '0;
            n_last <= n_last_nxt;
         end else if (xfer) begin
            if (last) begin
               state <= IDLE;
               sel   <= '0;
            end else begin
               sel <= sel + CW'(1);
            end
         end

         if (drop) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         frame <= bus.d_in;
      end
   end

   assign busy          = valid;
   assign bus.out_valid = valid;
   assign bus.d_out     = frame[sel*W +: W];
   assign bus.ch_idx    = sel;
   assign bus.ch_onehot = valid ? (ONE << sel) : '0;
   assign bus.sof       = valid & (sel == '0);
   assign bus.eof       = valid & last;

endmodule

// File: tb/tb_ch_serializer.sv
// Directed bench for ch_serializer with a sample scoreboard checked on every transfer.
module tb_ch_serializer;
   localparam int NCH = 8;
   localparam int W   = 16;

   typedef struct {
      logic [W-1:0] d;
      int           idx;
      logic         sof;
      logic         eof;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic clr_overrun;
   logic busy;
   logic overrun;
   logic mon_en = 1'b0;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];
   exp_t e;
   logic [NCH*W-1:0] din;
   logic [NCH*W-1:0] din_b;

   ch_serializer_if #(.NCH(NCH), .W(W)) bus ();

   ch_serializer #(.NCH(NCH), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .clr_overrun (clr_overrun),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      bus.in_strobe = 1'b1;
      tick();
      bus.in_strobe = 1'b0;
   endtask

   task automatic push_frame(input int n, input logic [NCH*W-1:0] d);
      exp_t x;
      for (int k = 0; k < n; k++) begin
         x.d   = d[k*W +: W];
         x.idx = k;
         x.sof = (k == 0);
         x.eof = (k == n - 1);
         sb.push_back(x);
      end
   endtask

   task automatic rand_frame(output logic [NCH*W-1:0] d);
      for (int k = 0; k < NCH; k++) d[k*W +: W] = W'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.out_valid === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, bus.out_valid, 1'b0);
   endtask

   // Scoreboard: every accepted sample must match the head of the expected queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL sb_underflow: observed sample d_out=%0h idx=%0d, expected none", bus.d_out, bus.ch_idx);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sample_data", bus.d_out, e.d);
               chk("sample_idx", bus.ch_idx, e.idx);
               chk("sample_onehot", bus.ch_onehot, 64'(1) << e.idx);
               chk("sample_sof", bus.sof, e.sof);
               chk("sample_eof", bus.eof, e.eof);
            end
         end else if (bus.out_valid !== 1'b1) begin
            chk("idle_onehot", bus.ch_onehot, 0);
            chk("idle_sof", bus.sof, 1'b0);
            chk("idle_eof", bus.eof, 1'b0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of stimulus, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] c1;
      rst_n         = 1'b0;
      clr_overrun   = 1'b0;
      bus.numch     = '0;
      bus.in_strobe = 1'b0;
      bus.d_in      = '0;
      bus.out_ready = 1'b1;
      repeat (2) tick();

      // reset state
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_sof", bus.sof, 1'b0);
      chk("rst_eof", bus.eof, 1'b0);
      chk("rst_onehot", bus.ch_onehot, 0);
      chk("rst_idx", bus.ch_idx, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // four channels back to back at full rate
      rand_frame(din);
      for (int k = 0; k < 4; k++) din[k*W +: W] = W'(32'h1111 * (k + 1));
      bus.numch = 4;
      bus.d_in  = din;
      push_frame(4, din);
      chk("t1_pre_valid", bus.out_valid, 1'b0);
      strobe();
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", bus.out_valid, 1'b1);
         chk("t1_busy", busy, 1'b1);
         chk("t1_idx", bus.ch_idx, i);
         tick();
      end
      chk("t1_end_valid", bus.out_valid, 1'b0);
      chk("t1_end_busy", busy, 1'b0);
      chk("t1_drain", sb.size(), 0);

      // stall at channel 1
      rand_frame(din);
      c1 = din[W +: W];
      bus.numch = 3;
      bus.d_in  = din;
      push_frame(3, din);
      strobe();
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_data", bus.d_out, c1);
         chk("t2_hold_onehot", bus.ch_onehot, 8'b0000_0010);
         chk("t2_hold_idx", bus.ch_idx, 1);
         tick();
      end
      bus.out_ready = 1'b1;
      wait_idle("t2_idle");
      chk("t2_drain", sb.size(), 0);

      // strobe on the final transfer chains without a bubble
      rand_frame(din);
      rand_frame(din_b);
      bus.numch = 2;
      bus.d_in  = din;
      push_frame(2, din);
      strobe();
      chk("t3_valid0", bus.out_valid, 1'b1);
      tick();
      chk("t3_valid1", bus.out_valid, 1'b1);
      bus.d_in = din_b;
      push_frame(2, din_b);
      strobe();
      chk("t3_valid2", bus.out_valid, 1'b1);
      chk("t3_sof2", bus.sof, 1'b1);
      tick();
      chk("t3_valid3", bus.out_valid, 1'b1);
      tick();
      chk("t3_end_valid", bus.out_valid, 1'b0);
      chk("t3_overrun", overrun, 1'b0);
      chk("t3_drain", sb.size(), 0);

      // strobe mid-frame is dropped; numch change mid-frame is ignored
      rand_frame(din);
      rand_frame(din_b);
      bus.numch = 8;
      bus.d_in  = din;
      push_frame(8, din);
      strobe();
      bus.numch = 2;
      repeat (3) tick();
      chk("t4_sel3", bus.ch_idx, 3);
      bus.d_in = din_b;
      strobe();
      chk("t4_overrun_set", overrun, 1'b1);
      wait_idle("t4_idle");
      chk("t4_drain", sb.size(), 0);
      repeat (3) tick();
      chk("t4_overrun_sticky", overrun, 1'b1);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("t4_overrun_clr", overrun, 1'b0);

      // simultaneous set and clear: set wins
      rand_frame(din);
      bus.d_in = din;
      push_frame(2, din);
      strobe();
      bus.in_strobe = 1'b1;
      clr_overrun   = 1'b1;
      tick();
      bus.in_strobe = 1'b0;
      clr_overrun   = 1'b0;
      chk("t4_set_wins", overrun, 1'b1);
      wait_idle("t4b_idle");
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("t4b_overrun_clr", overrun, 1'b0);
      chk("t4b_drain", sb.size(), 0);

      // numch = 0 ignores strobes
      bus.numch = 0;
      strobe();
      for (int i = 0; i < 3; i++) begin
         chk("t5_zero_valid", bus.out_valid, 1'b0);
         chk("t5_zero_overrun", overrun, 1'b0);
         tick();
      end

      // numch above NCH clamps to NCH
      rand_frame(din);
      bus.numch = 12;
      bus.d_in  = din;
      push_frame(8, din);
      strobe();
      wait_idle("t5_clamp_idle");
      chk("t5_clamp_drain", sb.size(), 0);

      // single channel: sof and eof together
      rand_frame(din);
      bus.numch = 1;
      bus.d_in  = din;
      push_frame(1, din);
      strobe();
      chk("t5_one_sof", bus.sof, 1'b1);
      chk("t5_one_eof", bus.eof, 1'b1);
      tick();
      chk("t5_one_idle", bus.out_valid, 1'b0);
      chk("t5_one_drain", sb.size(), 0);

      // reset mid-frame abandons the frame
      rand_frame(din);
      bus.numch = 4;
      bus.d_in  = din;
      push_frame(4, din);
      strobe();
      repeat (2) tick();
      chk("t6_sel2", bus.ch_idx, 2);
      rst_n = 1'b0;
      tick();
      sb.delete();
      chk("t6_rst_valid", bus.out_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_idx", bus.ch_idx, 0);
      chk("t6_rst_onehot", bus.ch_onehot, 0);
      chk("t6_rst_sof", bus.sof, 1'b0);
      chk("t6_rst_eof", bus.eof, 1'b0);
      chk("t6_rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("t6_post_valid", bus.out_valid, 1'b0);
      rand_frame(din);
      bus.d_in = din;
      push_frame(4, din);
      strobe();
      chk("t6_restart_idx", bus.ch_idx, 0);
      chk("t6_restart_sof", bus.sof, 1'b1);
      wait_idle("t6_idle");
      chk("t6_drain", sb.size(), 0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
